// File: rtl/bullet_scheduler.sv
// bullet_scheduler: shares a pool of bullet slots between player and enemy shooters with cooldown and round-robin arbitration
module bullet_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int COOLDOWN  = 15,
  parameter int CNT_W     = 8
) (
  input  logic                 clk_60hz,
  input  logic                 reset,
  input  logic                 fire_player,
  input  logic                 fire_enemy,
  input  logic [9:0]           player_x,
  input  logic [9:0]           enemy_x,
  input  logic [NUM_SLOTS-1:0] slot_in_use,
  output logic [NUM_SLOTS-1:0] start_bullet,
  output logic                 direction,
  output logic [9:0]           bullet_x,
  output logic                 grant_player,
  output logic                 grant_enemy,
  output logic [CNT_W-1:0]     drop_count
);
  logic                 fire_p_q, fire_e_q, pend_p_q, pend_e_q, rr_q;
  logic                 pend_p_d, pend_e_d, rr_d;
  logic [CNT_W-1:0]     cd_p_q, cd_e_q, drop_q, cd_p_d, cd_e_d, drop_d;
  logic [NUM_SLOTS-1:0] start_q, start_d, free, sel;
  logic                 dir_q, dir_d, gnt_p_q, gnt_p_d, gnt_e_q, gnt_e_d;
  logic [9:0]           bx_q, bx_d;
  logic                 any_free, win_p, win_e;
  logic [CNT_W:0]       drop_sum;
  // Arbitrate pending shooters onto the lowest free slot not granted last cycle
  always_comb begin
    free     = ~slot_in_use & ~start_q;
    sel      = free & (~free + NUM_SLOTS'(1));
    any_free = |free;
    win_p    = any_free & pend_p_q & (~pend_e_q | ~rr_q);
    win_e    = any_free & pend_e_q & (~pend_p_q | rr_q);
    pend_p_d = pend_p_q ? any_free & ~win_p : fire_player & ~fire_p_q & (cd_p_q == '0);
    pend_e_d = pend_e_q ? any_free & ~win_e : fire_enemy & ~fire_e_q & (cd_e_q == '0);
    cd_p_d   = win_p ? CNT_W'(COOLDOWN) : cd_p_q - CNT_W'(cd_p_q != '0);
    cd_e_d   = win_e ? CNT_W'(COOLDOWN) : cd_e_q - CNT_W'(cd_e_q != '0);
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(~any_free & pend_p_q) + (CNT_W+1)'(~any_free & pend_e_q);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    rr_d     = rr_q ^ (pend_p_q & pend_e_q & any_free);
    start_d  = (win_p | win_e) ? sel : '0;
    dir_d    = win_p;
    bx_d     = win_p ? player_x : win_e ? enemy_x : '0;
    gnt_p_d  = win_p;
    gnt_e_d  = win_e;
  end
  // Frame-rate state; fire history resets as if held so a button down through reset needs a release first
  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      fire_p_q <= 1'b1;
      fire_e_q <= 1'b1;
      pend_p_q <= 1'b0;
      pend_e_q <= 1'b0;
      rr_q     <= 1'b0;
      cd_p_q   <= '0;
      cd_e_q   <= '0;
      drop_q   <= '0;
      start_q  <= '0;
      dir_q    <= 1'b0;
      bx_q     <= '0;
      gnt_p_q  <= 1'b0;
      gnt_e_q  <= 1'b0;
    end else begin
      fire_p_q <= fire_player;
      fire_e_q <= fire_enemy;
      pend_p_q <= pend_p_d;
      pend_e_q <= pend_e_d;
      rr_q     <= rr_d;
      cd_p_q   <= cd_p_d;
      cd_e_q   <= cd_e_d;
      drop_q   <= drop_d;
      start_q  <= start_d;
      dir_q    <= dir_d;
      bx_q     <= bx_d;
      gnt_p_q  <= gnt_p_d;
      gnt_e_q  <= gnt_e_d;
    end
  end
  assign start_bullet = start_q;
  assign direction    = dir_q;
  assign bullet_x     = bx_q;
  assign grant_player = gnt_p_q;
  assign grant_enemy  = gnt_e_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: directed and randomized checks of bullet_scheduler against a behavioural model
module tb_bullet_scheduler;
  logic       clk_60hz = 1'b0, reset = 1'b1, fire_player = 1'b0, fire_enemy = 1'b0;
  logic [9:0] player_x = '0, enemy_x = '0;
  logic [7:0] slot_in_use = '0;
  logic [7:0] start_bullet, drop_count;
  logic       direction, grant_player, grant_enemy;
  logic [9:0] bullet_x;
  int tests = 0, fails = 0;

  bullet_scheduler #(.NUM_SLOTS(8), .COOLDOWN(15), .CNT_W(8)) dut (
    .clk_60hz(clk_60hz), .reset(reset), .fire_player(fire_player), .fire_enemy(fire_enemy),
    .player_x(player_x), .enemy_x(enemy_x), .slot_in_use(slot_in_use),
    .start_bullet(start_bullet), .direction(direction), .bullet_x(bullet_x),
    .grant_player(grant_player), .grant_enemy(grant_enemy), .drop_count(drop_count)
  );

  always #5 clk_60hz = ~clk_60hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: per-shooter pending flag and frame countdown, integer slot search
  bit         m_fp, m_fe, m_pp, m_pe, m_rr, e_dir, e_gp, e_ge;
  int         m_cdp, m_cde, m_drop, m_last;
  logic [7:0] e_start;
  logic [9:0] e_bx;

  always @(posedge clk_60hz or posedge reset) begin : model
    int  sel, w;
    bit  evp, eve;
    if (reset) begin
      m_fp = 1; m_fe = 1; m_pp = 0; m_pe = 0; m_rr = 0;
      m_cdp = 0; m_cde = 0; m_drop = 0; m_last = -1;
      e_start = '0; e_dir = 0; e_bx = '0; e_gp = 0; e_ge = 0;
    end else begin
      evp = fire_player && !m_fp;
      eve = fire_enemy && !m_fe;
      sel = -1;
      for (int i = 0; i < 8; i++)
        if (sel < 0 && !slot_in_use[i] && i != m_last) sel = i;
      w = -1;
      if (sel >= 0) begin
        if (m_pp && m_pe) begin
          w = m_rr ? 1 : 0;
          m_rr = !m_rr;
        end else if (m_pp) w = 0;
        else if (m_pe) w = 1;
      end else begin
        m_drop = m_drop + int'(m_pp) + int'(m_pe);
        if (m_drop > 255) m_drop = 255;
      end
      if (m_pp) m_pp = (sel >= 0) && (w != 0); else m_pp = evp && m_cdp == 0;
      if (m_pe) m_pe = (sel >= 0) && (w != 1); else m_pe = eve && m_cde == 0;
      if (w == 0) m_cdp = 15; else if (m_cdp > 0) m_cdp--;
      if (w == 1) m_cde = 15; else if (m_cde > 0) m_cde--;
      e_start = (w >= 0) ? 8'(1 << sel) : 8'h00;
      e_dir   = (w == 0);
      e_bx    = (w == 0) ? player_x : (w == 1) ? enemy_x : 10'd0;
      e_gp    = (w == 0);
      e_ge    = (w == 1);
      m_last  = (w >= 0) ? sel : -1;
      m_fp    = fire_player;
      m_fe    = fire_enemy;
    end
  end

  // Every cycle out of reset, all outputs must match the model
  always @(negedge clk_60hz) begin
    if (!reset) begin
      tests++;
      if ({start_bullet, direction, bullet_x, grant_player, grant_enemy, drop_count} !==
          {e_start, e_dir, e_bx, e_gp, e_ge, 8'(m_drop)}) begin
        fails++;
        $display("FAIL model t=%0t: got start=%h dir=%b x=%0d gp=%b ge=%b drop=%0d expected start=%h dir=%b x=%0d gp=%b ge=%b drop=%0d",
                 $time, start_bullet, direction, bullet_x, grant_player, grant_enemy, drop_count,
                 e_start, e_dir, e_bx, e_gp, e_ge, m_drop);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_60hz);
  endtask

  initial begin
    // held fire through reset must not fire
    fire_player = 1;
    cyc(2);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("held_no_start", start_bullet, 0);
    end
    chk("held_no_grant", grant_player, 0);
    chk("reset_drop", drop_count, 0);
    fire_player = 0;
    cyc(1);
    // single player shot, two-cycle latency, slot 0
    player_x = 10'd123; fire_player = 1;
    cyc(1);
    chk("lat_n1_start", start_bullet, 0);
    cyc(1);
    chk("p_start", start_bullet, 8'h01);
    chk("p_dir", direction, 1);
    chk("p_x", bullet_x, 123);
    chk("p_grant", grant_player, 1);
    fire_player = 0;
    cyc(20);
    // contention: player first, enemy next cycle on slot 1
    player_x = 10'd50; enemy_x = 10'd600; fire_player = 1; fire_enemy = 1;
    cyc(2);
    chk("rr0_start", start_bullet, 8'h01);
    chk("rr0_gp", grant_player, 1);
    cyc(1);
    chk("rr0_e_start", start_bullet, 8'h02);
    chk("rr0_e_dir", direction, 0);
    chk("rr0_e_x", bullet_x, 600);
    chk("rr0_ge", grant_enemy, 1);
    fire_player = 0; fire_enemy = 0;
    cyc(20);
    // pointer has toggled: enemy goes first now
    fire_player = 1; fire_enemy = 1;
    cyc(2);
    chk("rr1_ge", grant_enemy, 1);
    chk("rr1_gp", grant_player, 0);
    cyc(1);
    chk("rr1_gp2", grant_player, 1);
    fire_player = 0; fire_enemy = 0;
    cyc(20);
    // cooldown: press 5 frames after grant ignored, press at frame 16 granted
    fire_player = 1;
    cyc(2);
    chk("cd_grant", grant_player, 1);
    fire_player = 0;
    cyc(4);
    fire_player = 1;
    cyc(1);
    fire_player = 0;
    for (int k = 6; k <= 15; k++) begin
      cyc(1);
      chk("cd_ignored", grant_player, 0);
    end
    fire_player = 1;
    cyc(1);
    chk("cd_pending", grant_player, 0);
    fire_player = 0;
    cyc(1);
    chk("cd_regrant", grant_player, 1);
    cyc(20);
    // pool full drops, then slot 4 the only free one
    slot_in_use = 8'hFF; fire_enemy = 1;
    cyc(2);
    chk("full_start", start_bullet, 0);
    chk("full_drop", drop_count, 1);
    fire_enemy = 0; slot_in_use = 8'hEF;
    cyc(1);
    fire_enemy = 1;
    cyc(2);
    chk("slot4_start", start_bullet, 8'h10);
    chk("slot4_ge", grant_enemy, 1);
    fire_enemy = 0;
    cyc(20);
    // drop counter saturates
    slot_in_use = 8'hFF;
    repeat (140) begin
      fire_player = 1; fire_enemy = 1;
      cyc(1);
      fire_player = 0; fire_enemy = 0;
      cyc(1);
    end
    chk("drop_sat", drop_count, 8'hFF);
    fire_player = 1;
    cyc(2);
    chk("drop_sat_more", drop_count, 8'hFF);
    fire_player = 0; slot_in_use = 8'h00;
    cyc(20);
    // reset mid-cooldown clears everything, next press granted
    fire_player = 1;
    cyc(2);
    chk("pre_rst_grant", grant_player, 1);
    fire_player = 0;
    cyc(3);
    reset = 1;
    #1;
    chk("rst_drop", drop_count, 0);
    chk("rst_start", start_bullet, 0);
    chk("rst_x", bullet_x, 0);
    cyc(1);
    reset = 0;
    cyc(1);
    fire_player = 1;
    cyc(2);
    chk("post_rst_grant", grant_player, 1);
    chk("post_rst_start", start_bullet, 8'h01);
    fire_player = 0;
    cyc(1);
    // randomized traffic
    repeat (3000) begin
      cyc(1);
      fire_player = ($urandom_range(0, 2) == 0);
      fire_enemy  = ($urandom_range(0, 2) == 0);
      player_x    = 10'($urandom);
      enemy_x     = 10'($urandom);
      slot_in_use = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom) & 8'($urandom) & 8'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
    end
    reset = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
